// File: rtl/spi_master_ctrl.sv
// Byte-oriented SPI master, one chip select, bursts with CS held low between bytes.
// Optional macro SPI_MASTER_LSB_FIRST_EN shifts both directions LSB first.
module spi_master_ctrl #(
  parameter int SPI_MODE          = 0,
  parameter int CLKS_PER_HALF_BIT = 2,
  parameter int CS_INACTIVE_CLKS  = 4,
  parameter int COUNT_W           = 4
) (
  input  logic               i_Clk,
  input  logic               i_Rst_L,
  input  logic [COUNT_W-1:0] i_TX_Count,
  input  logic [7:0]         i_TX_Byte,
  input  logic               i_TX_DV,
  output logic               o_TX_Ready,
  output logic [7:0]         o_RX_Byte,
  output logic               o_RX_DV,
  output logic [COUNT_W-1:0] o_RX_Count,
  output logic               o_SPI_Clk,
  input  logic               i_SPI_MISO,
  output logic               o_SPI_MOSI,
  output logic               o_SPI_CS_n
);

  localparam logic CPOL = (SPI_MODE == 2) || (SPI_MODE == 3);
  localparam logic CPHA = (SPI_MODE == 1) || (SPI_MODE == 3);
`ifdef SPI_MASTER_LSB_FIRST_EN
  localparam logic LSB_FIRST = 1'b1;
`else
  localparam logic LSB_FIRST = 1'b0;
`endif

  localparam int HALF_W  = $clog2(CLKS_PER_HALF_BIT);
  localparam int INACT_W = $clog2(CS_INACTIVE_CLKS + 1);
  localparam logic [HALF_W-1:0]  HALF_LAST  = HALF_W'(CLKS_PER_HALF_BIT - 1);
  localparam logic [INACT_W-1:0] INACT_LOAD = INACT_W'(CS_INACTIVE_CLKS);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] CS_SETUP  = 3'd1;
  localparam logic [2:0] XFER      = 3'd2;
  localparam logic [2:0] WAIT_NEXT = 3'd3;
  localparam logic [2:0] CS_HOLD   = 3'd4;
  localparam logic [2:0] INACTIVE  = 3'd5;

  function automatic logic head_bit(input logic [7:0] v);
    return LSB_FIRST ? v[0] : v[7];
  endfunction

  function automatic logic [7:0] advance(input logic [7:0] v);
    return LSB_FIRST ? {1'b0, v[7:1]} : {v[6:0], 1'b0};
  endfunction

  function automatic logic [7:0] rx_push(input logic [7:0] v, input logic b);
    return LSB_FIRST ? {b, v[7:1]} : {v[6:0], b};
  endfunction

  logic [2:0]         state_q,     state_d;
  logic [HALF_W-1:0]  half_cnt_q,  half_cnt_d;
  logic [4:0]         edge_cnt_q,  edge_cnt_d;
  logic [INACT_W-1:0] inact_cnt_q, inact_cnt_d;
  logic [COUNT_W-1:0] remaining_q, remaining_d;
  logic [COUNT_W-1:0] rx_count_q,  rx_count_d;
  logic [7:0]         rx_byte_q,   rx_byte_d;
  logic               rx_dv_q,     rx_dv_d;
  logic               sclk_q,      sclk_d;
  logic               mosi_q,      mosi_d;
  logic               cs_n_q,      cs_n_d;
  logic [7:0]         tx_shift_q,  tx_shift_d;
  logic [7:0]         rx_shift_q,  rx_shift_d;

  logic accept;
  logic load;
  logic half_end;
  logic leading;
  logic sample_edge;
  logic last_edge;

  assign o_TX_Ready = (state_q == IDLE) || (state_q == WAIT_NEXT);
  assign accept     = i_TX_DV && o_TX_Ready;
  assign half_end   = (half_cnt_q == HALF_LAST);

  always_comb begin
    state_d     = state_q;
    half_cnt_d  = half_cnt_q;
    edge_cnt_d  = edge_cnt_q;
    inact_cnt_d = inact_cnt_q;
    remaining_d = remaining_q;
    rx_count_d  = rx_count_q;
    rx_byte_d   = rx_byte_q;
    rx_dv_d     = 1'b0;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
    cs_n_d      = cs_n_q;
    tx_shift_d  = tx_shift_q;
    rx_shift_d  = rx_shift_q;
    load        = 1'b0;
    leading     = ~edge_cnt_q[0];
    sample_edge = (leading != CPHA);
    last_edge   = (edge_cnt_q == 5'd15);

    case (state_q)
      IDLE: begin
        if (accept) begin
          load        = 1'b1;
          cs_n_d      = 1'b0;
          remaining_d = (i_TX_Count == '0) ? COUNT_W'(1) : i_TX_Count;
          rx_count_d  = '0;
          half_cnt_d  = '0;
          state_d     = CS_SETUP;
        end
      end
      CS_SETUP: begin
        if (half_end) begin
          half_cnt_d = '0;
          edge_cnt_d = '0;
          state_d    = XFER;
        end else begin
          half_cnt_d = half_cnt_q + 1'b1;
        end
      end
      XFER: begin
        if (half_end) begin
          half_cnt_d = '0;
          sclk_d     = ~sclk_q;
          edge_cnt_d = edge_cnt_q + 5'd1;
          if (sample_edge) begin
            rx_shift_d = rx_push(rx_shift_q, i_SPI_MISO);
            // Only the 8th sample edge has an index of 14 or above.
            if (edge_cnt_q >= 5'd14) begin
              rx_dv_d   = 1'b1;
              rx_byte_d = rx_push(rx_shift_q, i_SPI_MISO);
            end
          end else if (!last_edge) begin
            mosi_d     = head_bit(tx_shift_q);
            tx_shift_d = advance(tx_shift_q);
          end
          if (last_edge) begin
            remaining_d = remaining_q - 1'b1;
            state_d     = (remaining_q == COUNT_W'(1)) ? CS_HOLD : WAIT_NEXT;
          end
        end else begin
          half_cnt_d = half_cnt_q + 1'b1;
        end
      end
      WAIT_NEXT: begin
        if (accept) begin
          load       = 1'b1;
          rx_count_d = rx_count_q + 1'b1;
          half_cnt_d = '0;
          edge_cnt_d = '0;
          state_d    = XFER;
        end
      end
      CS_HOLD: begin
        if (half_end) begin
          half_cnt_d  = '0;
          cs_n_d      = 1'b1;
          mosi_d      = 1'b0;
          inact_cnt_d = INACT_LOAD;
          state_d     = INACTIVE;
        end else begin
          half_cnt_d = half_cnt_q + 1'b1;
        end
      end
      INACTIVE: begin
        if (inact_cnt_q <= INACT_W'(1)) begin
          state_d = IDLE;
        end else begin
          inact_cnt_d = inact_cnt_q - 1'b1;
        end
      end
      default: begin
        cs_n_d      = 1'b1;
        mosi_d      = 1'b0;
        sclk_d      = CPOL;
        inact_cnt_d = INACT_LOAD;
        state_d     = INACTIVE;
      end
    endcase

    // CPHA=0 presents the first bit before the first edge; CPHA=1 launches it on that edge.
    if (load) begin
      if (CPHA) begin
        tx_shift_d = i_TX_Byte;
      end else begin
        mosi_d     = head_bit(i_TX_Byte);
        tx_shift_d = advance(i_TX_Byte);
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q     <= INACTIVE;
      half_cnt_q  <= '0;
      edge_cnt_q  <= '0;
      inact_cnt_q <= INACT_LOAD;
      remaining_q <= '0;
      rx_count_q  <= '0;
      rx_byte_q   <= '0;
      rx_dv_q     <= 1'b0;
      sclk_q      <= CPOL;
      mosi_q      <= 1'b0;
      cs_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      half_cnt_q  <= half_cnt_d;
      edge_cnt_q  <= edge_cnt_d;
      inact_cnt_q <= inact_cnt_d;
      remaining_q <= remaining_d;
      rx_count_q  <= rx_count_d;
      rx_byte_q   <= rx_byte_d;
      rx_dv_q     <= rx_dv_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      cs_n_q      <= cs_n_d;
    end
  end

  always_ff @(posedge i_Clk) begin
    tx_shift_q <= tx_shift_d;
    rx_shift_q <= rx_shift_d;
  end

  assign o_RX_Byte  = rx_byte_q;
  assign o_RX_DV    = rx_dv_q;
  assign o_RX_Count = rx_count_q;
  assign o_SPI_Clk  = sclk_q;
  assign o_SPI_MOSI = mosi_q;
  assign o_SPI_CS_n = cs_n_q;

endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
Byte-oriented SPI master with one chip select. It drives SCLK, MOSI and CS_n toward an SPI_Slave-class peripheral and samples MISO. Bursts of N bytes are sent with CS held low between bytes. A valid/ready handshake on the system side feeds TX bytes, and RX bytes come back as one-cycle strobes. The block sits between the host logic and the off-chip SPI pins, and is the initiator counterpart of the team's slave block.

Parameters:
SPI_MODE, 0, CPOL = (mode 2 or 3), CPHA = (mode 1 or 3); legal values 0-3
CLKS_PER_HALF_BIT, 2, i_Clk cycles per SCLK half-period; must be >= 2
CS_INACTIVE_CLKS, 4, minimum i_Clk cycles CS_n stays high between transactions; must be >= 1
COUNT_W, 4, width of burst-length and RX-count fields

Ports:
i_Clk  in  1  system clock; all logic on its rising edge
i_Rst_L  in  1  asynchronous active-low reset
i_TX_Count  in  COUNT_W  bytes in the transaction; sampled with the first accepted byte; 0 treated as 1
i_TX_Byte  in  8  byte to transmit
i_TX_DV  in  1  TX byte valid
o_TX_Ready  out  1  master can accept a TX byte this cycle
o_RX_Byte  out  8  last received byte
o_RX_DV  out  1  one-cycle strobe: o_RX_Byte updated
o_RX_Count  out  COUNT_W  index of the byte just received in this transaction (0-based)
o_SPI_Clk  out  1  SCLK
i_SPI_MISO  in  1  serial data from slave
o_SPI_MOSI  out  1  serial data to slave
o_SPI_CS_n  out  1  active-low chip select

Behaviour:
- Reset values: o_SPI_Clk=CPOL, o_SPI_CS_n=1, o_SPI_MOSI=0, o_TX_Ready=0, o_RX_DV=0, o_RX_Byte=0, o_RX_Count=0. State=INACTIVE with CS_INACTIVE_CLKS loaded, so o_TX_Ready rises CS_INACTIVE_CLKS cycles after reset release.
- Handshake: a byte is accepted on a cycle where i_TX_DV and o_TX_Ready are both 1. o_TX_Ready drops the next cycle. i_TX_DV with o_TX_Ready=0 is ignored, with no side effects.
- FSM states: IDLE, CS_SETUP, XFER, WAIT_NEXT, CS_HOLD, INACTIVE.
- IDLE: o_TX_Ready=1.
  - On accept: latch byte; remaining = max(i_TX_Count,1); o_RX_Count=0; CS_n goes 0 next cycle; go to CS_SETUP.
- CS_SETUP: lasts CLKS_PER_HALF_BIT cycles, then go to XFER.
  - CPHA=0: MOSI = bit7 throughout CS_SETUP.
- XFER: 16 SCLK edges, one every CLKS_PER_HALF_BIT cycles, so each byte takes 16*CLKS_PER_HALF_BIT cycles. Data is MSB first.
  - CPHA=0: sample MISO on leading edges; update MOSI on trailing edges (except after the final edge).
  - CPHA=1: update MOSI on leading edges; sample on trailing edges.
- Byte completion, after the 8th sample edge:
  - o_RX_DV pulses 1 cycle, with o_RX_Byte and o_RX_Count valid in the same cycle.
  - remaining decrements.
  - SCLK returns to CPOL after the 16th edge.
- After XFER:
  - If remaining > 0, go to WAIT_NEXT: o_TX_Ready=1, CS_n held low indefinitely, SCLK idle. On accept, go directly to XFER; MOSI = new bit7 for CPHA=0. o_RX_Count increments at each following byte.
  - If remaining = 0, go to CS_HOLD.
- CS_HOLD: lasts CLKS_PER_HALF_BIT cycles, then CS_n=1 and go to INACTIVE.
- INACTIVE: lasts CS_INACTIVE_CLKS cycles, then go to IDLE. MOSI=0 while CS_n=1.
- SCLK never toggles while CS_n=1. No glitches: SCLK, MOSI and CS_n are registered outputs.
- Asynchronous reset mid-transfer: all outputs return to reset values immediately and the transaction is discarded. No o_RX_DV is issued for the partial byte.
- remaining and edge counters are COUNT_W and 5 bits wide. With COUNT_W=4, i_TX_Count=15 gives 15 bytes with o_RX_Count 0..14.

Optional Feature:
- Macro: SPI_MASTER_LSB_FIRST_EN.
- Defined: bytes are shifted LSB first on MOSI, and the first MISO bit received lands in o_RX_Byte[0].
- Undefined: MSB first on both directions, compatible with the team's slave block. All timing is identical in both cases.

Test Plan:
- Mode 0, CLKS_PER_HALF_BIT=2, count 1, TX 0xA5, slave-model MISO returns 0x3C:
  - MOSI shows 1,0,1,0,0,1,0,1.
  - o_RX_DV pulses once with o_RX_Byte=0x3C and o_RX_Count=0.
  - CS_n low for exactly 16*2+2+2 = 36 cycles.
- Mode 0 burst, count 3, bytes 0x01,0x02,0x03 fed with a 5-cycle gap before the 2nd byte:
  - CS_n stays low across all bytes.
  - Three o_RX_DV strobes with o_RX_Count 0,1,2.
  - The slave model's received bytes match the transmitted ones.
- Mode 3, TX 0xF0:
  - o_SPI_Clk idles 1 before, during CS setup and after the transaction.
  - MOSI changes only on falling SCLK; MISO is sampled on rising SCLK; RX is correct.
- Busy-ignore and count 0:
  - i_TX_DV pulsed with 0x55 during XFER is not transmitted and o_TX_Ready stays 0.
  - i_TX_Count=0 sends exactly one byte.
- Reset at SCLK edge 7 of byte 0:
  - CS_n goes to 1, SCLK goes to CPOL and o_RX_DV stays 0, all immediately.
  - o_TX_Ready=1 exactly CS_INACTIVE_CLKS cycles after release.
- With SPI_MASTER_LSB_FIRST_EN, TX 0x01:
  - MOSI first bit is 1.
  - MISO sequence 1,0,0,0,0,0,0,0 yields o_RX_Byte=0x01.
